// File: rtl/fifo_rd_port_pkg.sv
// Shared FIFO sizing defaults and read-side valid-flag encodings.
// The fifo_mem writer imports the same values so both sides agree on widths.
package fifo_rd_port_pkg;

    localparam int unsigned FIFO_BITS  = 8;
    localparam int unsigned FIFO_DEPTH = 4;

    // Pointer width: the address bits plus one wrap bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam logic [0:0] VLD_IDLE = 1'b0;
    localparam logic [0:0] VLD_HOLD = 1'b1;

endpackage

// File: rtl/d_ff_n.sv
// N-bit data register with asynchronous active-low clear.
module d_ff_n #(
    parameter int unsigned bits = 8
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [bits-1:0] Din_n,
    output logic [bits-1:0] q
);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q <= '0;
        end else begin
            q <= Din_n;
        end
    end

endmodule

// File: rtl/fifo_rd_port.sv
// Read-side controller for fifo_mem: owns the read pointer, derives empty/count/overflow,
// and pops words into a registered output stage with a valid/ready handshake.
module fifo_rd_port
    import fifo_rd_port_pkg::*;
#(
    parameter int unsigned bits  = FIFO_BITS,
    parameter int unsigned depth = FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [bits*depth-1:0]   mem_flat,
    input  logic [$clog2(depth):0]  wr_ptr,
    input  logic                    flush,
    output logic [$clog2(depth):0]  rd_ptr,
    output logic                    empty,
    output logic [$clog2(depth):0]  count,
    output logic [bits-1:0]         dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    ovf_err
);

    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned PW = ptr_width(depth);

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [0:0]      vld_q, vld_d;
    logic            ovf_q, ovf_d;
    logic            pop_c;
    logic [AW-1:0]   rd_idx;
    logic [bits-1:0] word_c;
    logic [bits-1:0] din_c;

    // Storage status is purely a function of the two pointers (mod 2^PW).
    assign empty  = (wr_ptr == rd_ptr_q);
    assign count  = wr_ptr - rd_ptr_q;
    assign rd_idx = rd_ptr_q[AW-1:0];
    assign word_c = mem_flat[int'(rd_idx) * int'(bits) +: bits];

    assign pop_c = !empty && (!dout_valid || dout_ready) && !flush;
    assign din_c = pop_c ? word_c : dout;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rd_ptr_q <= '0;
            vld_q    <= VLD_IDLE;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            vld_q    <= vld_d;
            ovf_q    <= ovf_d;
        end
    end

    // Flush overrides everything; otherwise HOLD drains to IDLE only when nothing refills it.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        vld_d    = vld_q;
        ovf_d    = ovf_q | (32'(count) > depth);
        if (flush) begin
            rd_ptr_d = wr_ptr;
            vld_d    = VLD_IDLE;
        end else begin
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case (vld_q)
                VLD_IDLE: if (pop_c) vld_d = VLD_HOLD;
                VLD_HOLD: if (dout_ready && !pop_c) vld_d = VLD_IDLE;
                default:  vld_d = VLD_IDLE;
            endcase
        end
    end

    d_ff_n #(.bits(bits)) u_dout_reg (
        .clk   (clk),
        .clr   (clr),
        .Din_n (din_c),
        .q     (dout)
    );

    assign rd_ptr     = rd_ptr_q;
    assign dout_valid = (vld_q == VLD_HOLD);
    assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_fifo_rd_port.sv
// Directed, table-driven bench for fifo_rd_port (bits=8, depth=4).
module tb_fifo_rd_port;

    logic        clk;
    logic        clr;
    logic [31:0] mem_flat;
    logic [2:0]  wr_ptr;
    logic        flush;
    logic [2:0]  rd_ptr;
    logic        empty;
    logic [2:0]  count;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        ovf_err;

    int total = 0;
    int bad   = 0;

    fifo_rd_port #(.bits(8), .depth(4)) dut (
        .clk        (clk),
        .clr        (clr),
        .mem_flat   (mem_flat),
        .wr_ptr     (wr_ptr),
        .flush      (flush),
        .rd_ptr     (rd_ptr),
        .empty      (empty),
        .count      (count),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    typedef struct {
        logic        pre_rst;
        logic [2:0]  wr;
        logic        fl;
        logic        rdy;
        logic [31:0] mem;
        logic [2:0]  e_rd;
        logic        e_empty;
        logic [2:0]  e_cnt;
        logic [7:0]  e_dout;
        logic        e_valid;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic p, input logic [2:0] w, input logic f,
                                input logic r, input logic [31:0] m,
                                input logic [2:0] erd, input logic ee, input logic [2:0] ec,
                                input logic [7:0] ed, input logic ev, input logic eo);
        vec_t v;
        v.pre_rst = p;   v.wr = w;       v.fl = f;      v.rdy = r;     v.mem = m;
        v.e_rd = erd;    v.e_empty = ee; v.e_cnt = ec;  v.e_dout = ed;
        v.e_valid = ev;  v.e_ovf = eo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    initial begin
        // Single word with long backpressure, then drain.
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(0, 1, 0, 0, 32'h000000A5, 1, 1, 0, 8'hA5, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 32'h000000A5, 1, 1, 0, 8'hA5, 0, 0));
        // Streaming across the pointer wrap (wr 4 then 8 == 0 mod 8).
        tbl.push_back(mk(1, 4, 0, 1, 32'h44332211, 1, 0, 3, 8'h11, 1, 0));
        tbl.push_back(mk(0, 4, 0, 1, 32'h44332211, 2, 0, 2, 8'h22, 1, 0));
        tbl.push_back(mk(0, 4, 0, 1, 32'h44332211, 3, 0, 1, 8'h33, 1, 0));
        tbl.push_back(mk(0, 4, 0, 1, 32'h44332211, 4, 1, 0, 8'h44, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h44332211, 5, 0, 3, 8'h11, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h44332211, 6, 0, 2, 8'h22, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h44332211, 7, 0, 1, 8'h33, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h44332211, 0, 1, 0, 8'h44, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h44332211, 0, 1, 0, 8'h44, 0, 0));
        // Backpressure 1,0,0,1 on four stored words.
        tbl.push_back(mk(0, 4, 0, 1, 32'hDDCCBBAA, 1, 0, 3, 8'hAA, 1, 0));
        tbl.push_back(mk(0, 4, 0, 0, 32'hDDCCBBAA, 1, 0, 3, 8'hAA, 1, 0));
        tbl.push_back(mk(0, 4, 0, 0, 32'hDDCCBBAA, 1, 0, 3, 8'hAA, 1, 0));
        tbl.push_back(mk(0, 4, 0, 1, 32'hDDCCBBAA, 2, 0, 2, 8'hBB, 1, 0));
        tbl.push_back(mk(0, 4, 0, 1, 32'hDDCCBBAA, 3, 0, 1, 8'hCC, 1, 0));
        tbl.push_back(mk(0, 4, 0, 0, 32'hDDCCBBAA, 3, 0, 1, 8'hCC, 1, 0));
        tbl.push_back(mk(0, 4, 0, 1, 32'hDDCCBBAA, 4, 1, 0, 8'hDD, 1, 0));
        tbl.push_back(mk(0, 4, 0, 1, 32'hDDCCBBAA, 4, 1, 0, 8'hDD, 0, 0));
        // Full (count == depth, no overflow), stage one, then flush with ready low.
        tbl.push_back(mk(0, 0, 0, 0, 32'h55443322, 5, 0, 3, 8'h22, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h55443322, 0, 1, 0, 8'h22, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h55443322, 0, 1, 0, 8'h22, 0, 0));
        // Overflow: wr = rd + 5, then corrected; flag stays sticky.
        tbl.push_back(mk(0, 5, 0, 0, 32'h55443322, 1, 0, 4, 8'h22, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 32'h55443322, 1, 1, 0, 8'h22, 1, 1));
        tbl.push_back(mk(0, 1, 0, 1, 32'h55443322, 1, 1, 0, 8'h22, 0, 1));

        // Reset with random inputs.
        clr        = 1'b0;
        mem_flat   = $urandom;
        wr_ptr     = 3'($urandom_range(7));
        flush      = 1'($urandom_range(1));
        dout_ready = 1'($urandom_range(1));
        #1;
        chk("rst_async_rd",    32'(rd_ptr),     0);
        chk("rst_async_valid", 32'(dout_valid), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd",    32'(rd_ptr),     0);
        chk("rst_dout",  32'(dout),       0);
        chk("rst_valid", 32'(dout_valid), 0);
        chk("rst_ovf",   32'(ovf_err),    0);

        @(negedge clk);
        wr_ptr = 3'd0; flush = 1'b0; dout_ready = 1'b0; mem_flat = 32'h000000A5;
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_rd",    32'(rd_ptr),     0);
        chk("idle_empty", 32'(empty),      1);
        chk("idle_count", 32'(count),      0);
        chk("idle_dout",  32'(dout),       0);
        chk("idle_valid", 32'(dout_valid), 0);
        chk("idle_ovf",   32'(ovf_err),    0);

        foreach (tbl[i]) begin
            @(negedge clk);
            if (tbl[i].pre_rst) begin
                wr_ptr = 3'd0;
                clr    = 1'b0;
                #1;
                clr    = 1'b1;
            end
            wr_ptr     = tbl[i].wr;
            flush      = tbl[i].fl;
            dout_ready = tbl[i].rdy;
            mem_flat   = tbl[i].mem;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rd",    i), 32'(rd_ptr),     32'(tbl[i].e_rd));
            chk($sformatf("v%0d_empty", i), 32'(empty),      32'(tbl[i].e_empty));
            chk($sformatf("v%0d_count", i), 32'(count),      32'(tbl[i].e_cnt));
            chk($sformatf("v%0d_dout",  i), 32'(dout),       32'(tbl[i].e_dout));
            chk($sformatf("v%0d_valid", i), 32'(dout_valid), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d_ovf",   i), 32'(ovf_err),    32'(tbl[i].e_ovf));
        end

        // Sticky overflow holds through idle cycles, cleared only by clr.
        @(negedge clk);
        dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_sticky", 32'(ovf_err), 1);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("ovf_clr",       32'(ovf_err), 0);
        chk("ovf_clr_rd",    32'(rd_ptr),  0);
        chk("ovf_clr_count", 32'(count),   1);
        @(negedge clk);
        clr = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
